// File: rtl/game_pkg.sv
// Shared shooter constants: sprite geometry, screen limits and the packed
// {x, y} position format used by the bullet pools and the collision stage.
package game_pkg;

    localparam int MAX_PLAYER_BULLET = 4;

    localparam int BULLET_WIDTH    = 4;
    localparam int BULLET_HEIGHT   = 8;
    localparam int PLAYER_WIDTH    = 32;
    localparam int PLAYER_CENTER_Y = 440;

    localparam int SCREEN_W = 640;
    localparam int PARK_X   = 640;

    localparam int X_W   = 10;
    localparam int Y_W   = 9;
    localparam int POS_W = X_W + Y_W;

    typedef enum logic {
        SLOT_FREE   = 1'b0,
        SLOT_ACTIVE = 1'b1
    } slotState_e;

    // Off-screen to the right: x + BULLET_WIDTH never reaches a visible pixel.
    localparam logic [POS_W-1:0] PARK_POS = {X_W'(PARK_X), Y_W'(0)};

    function automatic logic [POS_W-1:0] packPos(input logic [X_W-1:0] x,
                                                 input logic [Y_W-1:0] y);
        return {x, y};
    endfunction

endpackage

// File: rtl/game_free_slot_finder.sv
// Lowest-index priority encoder over a free-slot mask; shared by the player
// and enemy bullet pools.
module game_free_slot_finder #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     freeMask,
    output logic [IDX_W-1:0] freeIdx,
    output logic             found
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        freeIdx = '0;
        found   = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (freeMask[k]) begin
                freeIdx = IDX_W'(k);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_player_bullet.sv
// Player-bullet pool: spawns from the player on fire, moves bullets up once
// per frame, and retires them off the top of the screen or on a collision hit.
module game_player_bullet #(
    parameter int MAX_PLAYER_BULLET = game_pkg::MAX_PLAYER_BULLET,
    parameter int BULLET_SPEED      = 4,
    parameter int FIRE_COOLDOWN     = 8
) (
    input  logic                                        i_Clk,
    input  logic                                        i_Rst,
    input  logic                                        i_FrameTick,
    input  logic                                        i_Clear,
    input  logic                                        i_Fire,
    input  logic [game_pkg::X_W-1:0]                    i_PlayerX,
    input  logic [MAX_PLAYER_BULLET-1:0]                i_BulletHit,
    output logic [game_pkg::POS_W*MAX_PLAYER_BULLET-1:0] o_BulletPos,
    output logic [MAX_PLAYER_BULLET-1:0]                o_BulletValid,
    output logic                                        o_FireEvent
);

    import game_pkg::*;

    localparam int CD_W  = (FIRE_COOLDOWN > 0) ? $clog2(FIRE_COOLDOWN + 1) : 1;
    localparam int IDX_W = (MAX_PLAYER_BULLET > 1) ? $clog2(MAX_PLAYER_BULLET) : 1;

    localparam logic [X_W-1:0] SPAWN_X_OFS = X_W'((PLAYER_WIDTH - BULLET_WIDTH) / 2);
    localparam logic [Y_W-1:0] SPAWN_Y     = Y_W'(PLAYER_CENTER_Y - BULLET_HEIGHT);
    localparam logic [Y_W-1:0] SPEED_Y     = Y_W'(BULLET_SPEED);

    slotState_e               slotState     [MAX_PLAYER_BULLET];
    slotState_e               slotStateNext [MAX_PLAYER_BULLET];
    logic [POS_W-1:0]         slotPos       [MAX_PLAYER_BULLET];
    logic [POS_W-1:0]         slotPosNext   [MAX_PLAYER_BULLET];
    logic [CD_W-1:0]          cooldown;
    logic [CD_W-1:0]          cooldownNext;
    logic                     fireEvent;
    logic                     fireEventNext;

    logic [MAX_PLAYER_BULLET-1:0] validVec;
    logic [MAX_PLAYER_BULLET-1:0] freeVec;
    logic [MAX_PLAYER_BULLET-1:0] hitMask;
    logic [IDX_W-1:0]             freeIdx;
    logic                         freeFound;
    logic                         spawn;

    always_comb begin
        validVec = '0;
        for (int k = 0; k < MAX_PLAYER_BULLET; k++) begin
            validVec[k] = (slotState[k] == SLOT_ACTIVE);
        end
    end

    // Free mask is taken from the registered state, so a slot retired this
    // cycle is not visible as free until the next one.
    assign freeVec = ~validVec;
    assign hitMask = i_BulletHit & validVec;

    game_free_slot_finder #(
        .N     (MAX_PLAYER_BULLET),
        .IDX_W (IDX_W)
    ) u_freeSlotFinder (
        .freeMask (freeVec),
        .freeIdx  (freeIdx),
        .found    (freeFound)
    );

    assign spawn = i_FrameTick && (cooldown == '0) && i_Fire && freeFound;

    always_comb begin
        cooldownNext  = cooldown;
        fireEventNext = spawn;
        if (i_FrameTick) begin
            if (cooldown != '0) begin
                cooldownNext = cooldown - 1'b1;
            end else if (spawn) begin
                cooldownNext = CD_W'(FIRE_COOLDOWN);
            end
        end

        for (int k = 0; k < MAX_PLAYER_BULLET; k++) begin
            slotStateNext[k] = slotState[k];
            slotPosNext[k]   = slotPos[k];
            // A hit wins over movement: the bullet retires where it is.
            if (hitMask[k]) begin
                slotStateNext[k] = SLOT_FREE;
                slotPosNext[k]   = PARK_POS;
            end else if (validVec[k] && i_FrameTick) begin
                if (slotPos[k][Y_W-1:0] < SPEED_Y) begin
                    slotStateNext[k] = SLOT_FREE;
                    slotPosNext[k]   = PARK_POS;
                end else begin
                    slotPosNext[k] = packPos(slotPos[k][POS_W-1:Y_W],
                                             slotPos[k][Y_W-1:0] - SPEED_Y);
                end
            end
            if (spawn && (freeIdx == IDX_W'(k))) begin
                slotStateNext[k] = SLOT_ACTIVE;
                slotPosNext[k]   = packPos(i_PlayerX + SPAWN_X_OFS, SPAWN_Y);
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst || i_Clear) begin
            for (int k = 0; k < MAX_PLAYER_BULLET; k++) begin
                slotState[k] <= SLOT_FREE;
                slotPos[k]   <= PARK_POS;
            end
            cooldown  <= '0;
            fireEvent <= 1'b0;
        end else begin
            for (int k = 0; k < MAX_PLAYER_BULLET; k++) begin
                slotState[k] <= slotStateNext[k];
                slotPos[k]   <= slotPosNext[k];
            end
            cooldown  <= cooldownNext;
            fireEvent <= fireEventNext;
        end
    end

    always_comb begin
        o_BulletPos = '0;
        for (int k = 0; k < MAX_PLAYER_BULLET; k++) begin
            o_BulletPos[k*POS_W +: POS_W] = slotPos[k];
        end
    end

    assign o_BulletValid = validVec;
    assign o_FireEvent   = fireEvent;

endmodule

// File: tb/tb_game_player_bullet.sv
// Directed and randomized bench for game_player_bullet against a slot-list
// reference model.
module tb_game_player_bullet;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          frameTick;
    logic          clear;
    logic          fire;
    logic [9:0]    playerX;
    logic [N-1:0]  bulletHit;
    logic [19*N-1:0] bulletPos;
    logic [N-1:0]  bulletValid;
    logic          fireEvent;

    game_player_bullet #(
        .MAX_PLAYER_BULLET (N),
        .BULLET_SPEED      (4),
        .FIRE_COOLDOWN     (8)
    ) dut (
        .i_Clk         (clk),
        .i_Rst         (rst),
        .i_FrameTick   (frameTick),
        .i_Clear       (clear),
        .i_Fire        (fire),
        .i_PlayerX     (playerX),
        .i_BulletHit   (bulletHit),
        .o_BulletPos   (bulletPos),
        .o_BulletValid (bulletValid),
        .o_FireEvent   (fireEvent)
    );

    always #5 clk = ~clk;

    int passCount  = 0;
    int failCount  = 0;
    int checkCount = 0;
    int evtPulses  = 0;

    // Reference model: plain per-slot integers.
    int mValid [N];
    int mX     [N];
    int mY     [N];
    int mCd;
    int mEvt;

    logic [19*N-1:0] parkAll;

    task automatic chk(input string tag, input logic [19*N-1:0] obs,
                       input logic [19*N-1:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelStep();
        int wasFree [N];
        int found;
        if (rst || clear) begin
            for (int k = 0; k < N; k++) begin
                mValid[k] = 0; mX[k] = 640; mY[k] = 0;
            end
            mCd  = 0;
            mEvt = 0;
            return;
        end
        for (int k = 0; k < N; k++) wasFree[k] = (mValid[k] == 0);
        for (int k = 0; k < N; k++) begin
            if (mValid[k] != 0 && bulletHit[k]) begin
                mValid[k] = 0; mX[k] = 640; mY[k] = 0;
            end else if (mValid[k] != 0 && frameTick) begin
                if (mY[k] < 4) begin
                    mValid[k] = 0; mX[k] = 640; mY[k] = 0;
                end else begin
                    mY[k] = mY[k] - 4;
                end
            end
        end
        mEvt = 0;
        if (frameTick) begin
            if (mCd > 0) begin
                mCd = mCd - 1;
            end else if (fire) begin
                found = -1;
                for (int k = N - 1; k >= 0; k--) if (wasFree[k] != 0) found = k;
                if (found >= 0) begin
                    mValid[found] = 1;
                    mX[found]     = int'(playerX) + 14;
                    mY[found]     = 432;
                    mCd           = 8;
                    mEvt          = 1;
                end
            end
        end
    endtask

    task automatic compareAll();
        logic [19*N-1:0] ePos;
        logic [N-1:0]    eV;
        for (int k = 0; k < N; k++) begin
            ePos[k*19 +: 19] = {10'(mX[k]), 9'(mY[k])};
            eV[k]            = (mValid[k] != 0);
        end
        chk("model_valid", 76'(bulletValid), 76'(eV));
        chk("model_pos", bulletPos, ePos);
        chk("model_event", 76'(fireEvent), 76'(mEvt));
    endtask

    task automatic step();
        modelStep();
        @(posedge clk);
        #1;
        if (fireEvent === 1'b1) evtPulses++;
        compareAll();
    endtask

    task automatic tick();
        frameTick = 1'b1;
        step();
        frameTick = 1'b0;
        step();
        step();
    endtask

    initial begin
        for (int k = 0; k < N; k++) parkAll[k*19 +: 19] = {10'd640, 9'd0};
        rst = 1'b1; clear = 1'b0; frameTick = 1'b0; fire = 1'b1;
        playerX = 10'd0; bulletHit = '0;

        // Reset with fire held.
        repeat (3) begin
            step();
            chk("rst_valid", 76'(bulletValid), 76'(0));
            chk("rst_pos", bulletPos, parkAll);
            chk("rst_event", 76'(fireEvent), 76'(0));
        end
        rst = 1'b0; fire = 1'b0;
        step();

        // First spawn and first move.
        playerX = 10'd300; fire = 1'b1; evtPulses = 0;
        tick();
        chk("spawn_pos", 76'(bulletPos[18:0]), 76'({10'd314, 9'd432}));
        chk("spawn_valid", 76'(bulletValid), 76'(4'b0001));
        chk("spawn_event_count", 76'(evtPulses), 76'(1));
        fire = 1'b0;
        tick();
        chk("move_pos", 76'(bulletPos[18:0]), 76'({10'd314, 9'd428}));

        // Held fire: spawns on ticks 1, 10, 19.
        clear = 1'b1; step(); clear = 1'b0;
        fire = 1'b1; evtPulses = 0;
        repeat (19) tick();
        chk("cooldown_valid", 76'(bulletValid), 76'(4'b0111));
        chk("cooldown_events", 76'(evtPulses), 76'(3));
        chk("cooldown_slot2", 76'(bulletPos[38 +: 19]), 76'({10'd314, 9'd432}));
        fire = 1'b0;

        // Travel to the top edge and retire.
        clear = 1'b1; step(); clear = 1'b0;
        fire = 1'b1; tick(); fire = 1'b0;
        repeat (108) tick();
        chk("top_pos", 76'(bulletPos[18:0]), 76'({10'd314, 9'd0}));
        chk("top_valid", 76'(bulletValid), 76'(4'b0001));
        tick();
        chk("offscreen_valid", 76'(bulletValid), 76'(0));
        chk("offscreen_pos", bulletPos, parkAll);

        // Hit with tick: slot1 parks, lowest free at cycle start (slot2) spawns.
        clear = 1'b1; step(); clear = 1'b0;
        fire = 1'b1; repeat (10) tick();
        fire = 1'b0; repeat (8) tick();
        fire = 1'b1; bulletHit = 4'b0010; frameTick = 1'b1;
        step();
        frameTick = 1'b0; bulletHit = '0;
        chk("hit_valid", 76'(bulletValid), 76'(4'b0101));
        chk("hit_park", 76'(bulletPos[19 +: 19]), 76'({10'd640, 9'd0}));
        step();
        bulletHit = 4'b1000; step(); bulletHit = '0; step();
        chk("hit_free_slot_noeffect", 76'(bulletValid), 76'(4'b0101));

        // Full pool, retry, then clear.
        repeat (18) tick();
        chk("full_valid", 76'(bulletValid), 76'(4'b1111));
        repeat (12) tick();
        bulletHit = 4'b0100; step(); bulletHit = '0; step();
        chk("full_hit_valid", 76'(bulletValid), 76'(4'b1011));
        tick();
        chk("respawn_valid", 76'(bulletValid), 76'(4'b1111));
        chk("respawn_slot2", 76'(bulletPos[38 +: 19]), 76'({10'd314, 9'd432}));
        frameTick = 1'b1; clear = 1'b1; step(); clear = 1'b0; frameTick = 1'b0;
        chk("clear_valid", 76'(bulletValid), 76'(0));
        chk("clear_pos", bulletPos, parkAll);
        fire = 1'b0;

        // Randomized traffic.
        repeat (600) begin
            rst       = ($urandom_range(0, 149) == 0);
            clear     = ($urandom_range(0, 99) == 0);
            frameTick = ($urandom_range(0, 2) == 0);
            fire      = ($urandom_range(0, 3) != 0);
            playerX   = 10'($urandom_range(0, 608));
            for (int k = 0; k < N; k++) bulletHit[k] = ($urandom_range(0, 9) == 0);
            step();
        end
        rst = 1'b0; clear = 1'b0; frameTick = 1'b0; fire = 1'b0; bulletHit = '0;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
